prio_encoder_rr: RTL and testbench
==================================

Name: prio_encoder_rr

Overview:
- Parametrised, registered successor to the team's 8:3 enable-gated encoder.
- Encodes an N-bit request vector into a binary index plus a one-hot grant, in one of two modes:
  - fixed priority: highest index wins;
  - round-robin: rotating pointer.
- Result is held in a single output register with a valid/ready handshake.
- Sits between request sources (interrupt lines, channel requests) and a downstream consumer that may stall.

Parameters:
- N, 8, number of request inputs; legal range 2..256, power of two not required.
- W, $clog2(N), index width; derived, never overridden.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- en, input, 1, capture enable; no new result is captured while low.
- mode, input, 1:
  - 0 = fixed priority, highest set index wins.
  - 1 = round-robin.
- req, input, N, request vector, bit i = request i.
- out_ready, input, 1, consumer accepts the result when high with out_valid.
- out_valid, output, 1, y/grant/multi hold a valid result.
- y, output, W, encoded winner index.
- grant, output, N, one-hot of y.
- multi, output, 1, more than one req bit was set at capture.

Behaviour:
- Reset (rst_n low at a clk edge):
  - out_valid=0, y=0, grant=0, multi=0.
  - Round-robin pointer ptr=0.
  - Reset mid-handshake discards any pending result; no partial state survives.
- Output register "free" = (!out_valid) | out_ready.
- Capture condition = free & en & (|req). On capture at edge k, from edge k:
  - out_valid=1;
  - y=winner;
  - grant=1<<winner;
  - multi=(popcount(req)>1).
- Latency: 1 clock from req/en sampled to out_valid.
- Back-to-back: with out_ready held high and a capture condition every cycle, a new result is produced every cycle.
- If free and no capture (en=0 or req=0): out_valid=0, y=0, grant=0, multi=0 next edge. Outputs are all-zero whenever out_valid=0.
- Stall: out_valid=1 & out_ready=0 → y/grant/multi/out_valid held. req, en and mode changes are ignored; ptr is unchanged.
- en=0 does not flush a pending result; it only blocks new captures.
- Fixed mode (mode=0): winner = highest i with req[i]=1. ptr is not modified.
- Round-robin mode (mode=1):
  - winner = first i with req[i]=1 scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - On capture, ptr <= (winner==N-1) ? 0 : winner+1.
  - Wrap is at N-1 even when N is not a power of two. ptr never holds a value ≥ N.
- Mode switch:
  - Sampled at the capture edge only.
  - ptr is retained across fixed-mode periods and resumes on return to round-robin.
- Arithmetic: the index is zero-extended to W bits. The popcount for multi needs only a ">1" detection, not a full count.
- Combinational req → output paths: none. All outputs are register driven.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 for 2 clks with req=8'hFF, en=1.
  - Required: out_valid=0, y=0, grant=0, multi=0 throughout. The first result after release is y=7 in mode 0.
- Fixed priority, N=8, mode=0, out_ready=1:
  - Stimulus: req=8'b0010_1010.
  - Required: one clk later y=5, grant=8'h20, multi=1. Then req=8'h01 → y=0, grant=8'h01, multi=0.
- Round-robin, N=8, mode=1, out_ready=1:
  - Stimulus: req=8'b1000_0101 held.
  - Required: successive y=0,2,7,0,2. ptr goes 1,3,0,1,3.
- Stall:
  - Stimulus: capture y=3, then out_ready=0 for 4 clks while req changes to 8'h80 and en toggles.
  - Required: y=3, out_valid=1 held. On out_ready=1, y=7 on the next clk.
- Enable/empty:
  - Stimulus: en=0 with req=8'hFF and no pending result.
  - Required: out_valid=0, y=0.
  - Stimulus: en=1, req=0.
  - Required: out_valid=0.
- Non-power-of-two wrap:
  - Stimulus: N=5, mode=1, req=5'b10001 held.
  - Required: y=0,4,0,4. ptr never exceeds 4.
  - Stimulus: rst_n pulsed mid-sequence.
  - Required: the next result is y=0.

Source files
------------

// File: rtl/prio_encoder_rr_if.sv
// Handshake bundle between request sources, the registered priority encoder and its consumer.
interface prio_encoder_rr_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic         en;
    logic         mode;
    logic [N-1:0] req;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] y;
    logic [N-1:0] grant;
    logic         multi;

    modport slave (
        input  en, mode, req, out_ready,
        output out_valid, y, grant, multi
    );

    modport master (
        output en, mode, req, out_ready,
        input  out_valid, y, grant, multi
    );
endinterface

// File: rtl/prio_encoder_rr.sv
// Registered N-input encoder: fixed (highest index wins) or round-robin priority,
// result held in one output register behind a valid/ready handshake.
module prio_encoder_rr #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    prio_encoder_rr_if.slave bus
);
    localparam int W = $clog2(N);

    logic [W-1:0] ptr_q, ptr_d;
    logic         valid_q, valid_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] grant_q, grant_d;
    logic         multi_q, multi_d;

    logic [W-1:0] fixWin;
    logic [W-1:0] rrWin;
    logic         rrFound;
    logic [W-1:0] win;
    logic         free;
    logic         capture;
    int           scanIdx;

    // Both candidate winners are computed every cycle; mode only picks one at capture.
    always_comb begin
        fixWin  = '0;
        rrWin   = '0;
        rrFound = 1'b0;
        scanIdx = 0;
        for (int i = 0; i < N; i++) begin
            if (bus.req[i]) fixWin = W'(i);
        end
        for (int off = 0; off < N; off++) begin
            scanIdx = int'(ptr_q) + off;
            if (scanIdx >= N) scanIdx = scanIdx - N;
            if (!rrFound && bus.req[W'(scanIdx)]) begin
                rrWin   = W'(scanIdx);
                rrFound = 1'b1;
            end
        end
    end

    always_comb begin
        free    = !valid_q || bus.out_ready;
        capture = free && bus.en && (|bus.req);
        win     = bus.mode ? rrWin : fixWin;

        valid_d = valid_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        multi_d = multi_q;
        ptr_d   = ptr_q;

        if (capture) begin
            valid_d = 1'b1;
            idx_d   = win;
            grant_d = N'(1) << win;
            multi_d = |(bus.req & (bus.req - 1'b1));
            if (bus.mode) begin
                // Wrap explicitly at N-1 so a non-power-of-two N never leaves ptr >= N.
                ptr_d = (win == W'(N - 1)) ? '0 : win + 1'b1;
            end
        end else if (free) begin
            valid_d = 1'b0;
            idx_d   = '0;
            grant_d = '0;
            multi_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            grant_q <= '0;
            multi_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            multi_q <= multi_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.y         = idx_q;
    assign bus.grant     = grant_q;
    assign bus.multi     = multi_q;
endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr with an N=8 and an N=5 instance.
module tb_prio_encoder_rr;
    logic clk;
    logic rst_n;
    logic rst5_n;
    int   tests;
    int   failed;

    prio_encoder_rr_if #(.N(8)) if8 ();
    prio_encoder_rr_if #(.N(5)) if5 ();

    prio_encoder_rr #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n),  .bus(if8.slave));
    prio_encoder_rr #(.N(5)) dut5 (.clk(clk), .rst_n(rst5_n), .bus(if5.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic mode, input logic [7:0] req, input logic rdy);
        if8.en        = en;
        if8.mode      = mode;
        if8.req       = req;
        if8.out_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic v, input logic [2:0] y,
                          input logic [7:0] g, input logic m);
        checkOutput({tag, ".valid"}, 32'(if8.out_valid), 32'(v));
        checkOutput({tag, ".y"},     32'(if8.y),         32'(y));
        checkOutput({tag, ".grant"}, 32'(if8.grant),     32'(g));
        checkOutput({tag, ".multi"}, 32'(if8.multi),     32'(m));
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rst_n     = 1'b0;
        rst5_n    = 1'b0;
        if5.en        = 1'b0;
        if5.mode      = 1'b0;
        if5.req       = '0;
        if5.out_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'hFF, 1'b1);

        // Reset held two clocks with requests present
        step(); check8("rst0", 0, 0, 8'h00, 0);
        step(); check8("rst1", 0, 0, 8'h00, 0);
        checkOutput("rst.ptr", 32'(dut8.ptr_q), 0);
        rst_n = 1'b1;
        step(); check8("postRst", 1, 7, 8'h80, 1);

        // Fixed priority
        applyStimulus(1'b1, 1'b0, 8'b0010_1010, 1'b1);
        step(); check8("fix2A", 1, 5, 8'h20, 1);
        applyStimulus(1'b1, 1'b0, 8'h01, 1'b1);
        step(); check8("fix01", 1, 0, 8'h01, 0);
        checkOutput("fix.ptr", 32'(dut8.ptr_q), 0);

        // Round robin over 8'b1000_0101
        applyStimulus(1'b1, 1'b1, 8'b1000_0101, 1'b1);
        step(); check8("rr0", 1, 0, 8'h01, 1); checkOutput("rr0.ptr", 32'(dut8.ptr_q), 1);
        step(); check8("rr1", 1, 2, 8'h04, 1); checkOutput("rr1.ptr", 32'(dut8.ptr_q), 3);
        step(); check8("rr2", 1, 7, 8'h80, 1); checkOutput("rr2.ptr", 32'(dut8.ptr_q), 0);
        step(); check8("rr3", 1, 0, 8'h01, 1); checkOutput("rr3.ptr", 32'(dut8.ptr_q), 1);
        step(); check8("rr4", 1, 2, 8'h04, 1); checkOutput("rr4.ptr", 32'(dut8.ptr_q), 3);

        // Stall: capture y=3, then hold against changing inputs
        applyStimulus(1'b1, 1'b0, 8'h08, 1'b1);
        step(); check8("stallCap", 1, 3, 8'h08, 0);
        applyStimulus(1'b0, 1'b1, 8'h80, 1'b0);
        step(); check8("stall0", 1, 3, 8'h08, 0);
        applyStimulus(1'b1, 1'b0, 8'h80, 1'b0);
        step(); check8("stall1", 1, 3, 8'h08, 0);
        applyStimulus(1'b0, 1'b1, 8'h80, 1'b0);
        step(); check8("stall2", 1, 3, 8'h08, 0);
        applyStimulus(1'b1, 1'b1, 8'h80, 1'b0);
        step(); check8("stall3", 1, 3, 8'h08, 0);
        checkOutput("stall.ptr", 32'(dut8.ptr_q), 3);
        applyStimulus(1'b1, 1'b0, 8'h80, 1'b1);
        step(); check8("unstall", 1, 7, 8'h80, 0);

        // Pointer retained across the fixed-mode period
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
        step(); check8("rrResume", 1, 3, 8'h08, 1);
        checkOutput("rrResume.ptr", 32'(dut8.ptr_q), 4);

        // Enable low / empty request
        applyStimulus(1'b0, 1'b0, 8'hFF, 1'b1);
        step(); check8("enLow", 0, 0, 8'h00, 0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        step(); check8("reqZero", 0, 0, 8'h00, 0);

        // en=0 does not flush a pending result
        applyStimulus(1'b1, 1'b0, 8'h04, 1'b0);
        step(); check8("pendCap", 1, 2, 8'h04, 0);
        applyStimulus(1'b0, 1'b0, 8'h04, 1'b0);
        step(); check8("pendHold", 1, 2, 8'h04, 0);
        applyStimulus(1'b0, 1'b0, 8'h04, 1'b1);
        step(); check8("pendDrain", 0, 0, 8'h00, 0);

        // Reset mid-handshake discards the pending result
        applyStimulus(1'b1, 1'b1, 8'h40, 1'b0);
        step(); check8("midCap", 1, 6, 8'h40, 0);
        rst_n = 1'b0;
        step(); check8("midRst", 0, 0, 8'h00, 0);
        checkOutput("midRst.ptr", 32'(dut8.ptr_q), 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

        // N=5 round-robin wrap at N-1
        rst5_n        = 1'b1;
        if5.en        = 1'b1;
        if5.mode      = 1'b1;
        if5.req       = 5'b10001;
        if5.out_ready = 1'b1;
        step();
        checkOutput("n5a.y", 32'(if5.y), 0); checkOutput("n5a.ptr", 32'(dut5.ptr_q), 1);
        checkOutput("n5a.multi", 32'(if5.multi), 1);
        checkOutput("n5a.grant", 32'(if5.grant), 32'h01);
        step();
        checkOutput("n5b.y", 32'(if5.y), 4); checkOutput("n5b.ptr", 32'(dut5.ptr_q), 0);
        checkOutput("n5b.grant", 32'(if5.grant), 32'h10);
        step();
        checkOutput("n5c.y", 32'(if5.y), 0); checkOutput("n5c.ptr", 32'(dut5.ptr_q), 1);
        step();
        checkOutput("n5d.y", 32'(if5.y), 4); checkOutput("n5d.ptr", 32'(dut5.ptr_q), 0);
        step();
        checkOutput("n5e.y", 32'(if5.y), 0); checkOutput("n5e.ptr", 32'(dut5.ptr_q), 1);

        // Reset pulse mid-sequence restarts the pointer at 0
        rst5_n = 1'b0;
        step();
        checkOutput("n5rst.valid", 32'(if5.out_valid), 0);
        checkOutput("n5rst.y", 32'(if5.y), 0);
        rst5_n = 1'b1;
        step();
        checkOutput("n5post.valid", 32'(if5.out_valid), 1);
        checkOutput("n5post.y", 32'(if5.y), 0);
        checkOutput("n5post.ptr", 32'(dut5.ptr_q), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
